puf_eval_ctrl: RTL and testbench
================================

PUF_EVAL_CTRL -- requirements
Module: puf_eval_ctrl

Interface
REQ-001 Parameter NUM_CH, default 8: number of parallel race channels, one response bit each.
REQ-002 Parameter CFG_W, default 128: PDL configuration width per delay line.
REQ-003 Parameter VOTE_CNT, default 7: evaluations per challenge; odd, range 1..31.
REQ-004 Parameter SETTLE_CYC, default 4: trig-high and trig-low hold time in cycles; range 1..255.
REQ-005 clk  in  1  sole clock; all logic on the rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 start  in  1  request an evaluation; accepted only in IDLE.
REQ-008 cfg1_in / cfg2_in  in  CFG_W each  challenge for PDL line 1 / line 2.
REQ-009 cfg1 / cfg2  out  CFG_W each  registered PDL configuration, held stable from LOAD until the next accept.
REQ-010 trig  out  1  registered race launch to both adder/PDL paths.
REQ-011 race_in  in  NUM_CH  arbiter (DFF) outputs; sampled only in SAMPLE.
REQ-012 resp  out  NUM_CH  majority-voted response.
REQ-013 resp_valid  out  1  resp valid; resp_ready  in  1  consumer accepts.
REQ-014 stable_mask  out  NUM_CH  per-bit unanimity flag; see Configuration.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 FSM states: IDLE, LOAD, FIRE, SAMPLE, RECOV, DONE.
REQ-017 IDLE with start=1: latch cfg1_in/cfg2_in into cfg1/cfg2, clear vote counters and vote index, go to LOAD.
REQ-018 LOAD: one cycle with trig=0 so the PDL configuration settles, then go to FIRE.
REQ-019 FIRE: trig=1 for SETTLE_CYC cycles, then go to SAMPLE.
REQ-020 SAMPLE: trig=1 for one cycle; each channel counter increments when race_in[i]=1; vote index increments.
REQ-021 RECOV: trig=0 for SETTLE_CYC cycles; then go to FIRE if the vote index is below VOTE_CNT, otherwise go to DONE.
REQ-022 Per-channel counter width is clog2(VOTE_CNT+1); it never wraps.
REQ-023 On entry to DONE, resp[i] = (count[i] > VOTE_CNT/2, integer division) and resp_valid=1.
REQ-024 Latency: resp_valid first high 1+VOTE_CNT*(2*SETTLE_CYC+1) cycles after the accept edge; 64 with the defaults.
REQ-025 DONE: resp, resp_valid and stable_mask hold until resp_valid and resp_ready are both high, then go to IDLE; resp_ready outside DONE is ignored.
REQ-026 start outside IDLE is ignored without side effects; start and handshake in the same DONE cycle does not accept, so the new start needs a fresh IDLE cycle.
REQ-027 cfg1/cfg2 change only on an accept edge; resp changes only on entry to DONE.
REQ-028 VOTE_CNT=1: single evaluation; resp equals the sampled race_in.

Reset
REQ-029 rst, in any state including mid-race, forces IDLE on the next edge: trig=0, resp_valid=0, busy=0, resp=0, stable_mask=0, cfg1=0, cfg2=0, counters and vote index =0.
REQ-030 start high during or in the cycle after rst release is accepted only once IDLE is reached with rst=0.

Configuration
REQ-031 Macro PUF_STABILITY_EN defined: on entry to DONE, stable_mask[i]=1 iff count[i] is 0 or VOTE_CNT (all votes agree).
REQ-032 PUF_STABILITY_EN undefined: stable_mask is tied to all-zeros, and the unanimity logic is not synthesised; all other behaviour is identical.

Verification
REQ-033 Defaults, race_in=8'hA5 constant, start pulse -> trig toggles 7 times, resp=8'hA5, resp_valid high 64 cycles after accept, stable_mask=8'hFF (macro on) or 8'h00 (macro off).
REQ-034 race_in bit0 =1 in votes 1-4 and 0 in votes 5-7, bit1 =1 in votes 1-3 only -> resp[0]=1, resp[1]=0, stable_mask[1:0]=2'b00.
REQ-035 resp_ready held low for 20 cycles in DONE -> resp and resp_valid stable throughout; start pulses ignored; IDLE one cycle after ready rises.
REQ-036 rst asserted in the third FIRE cycle of vote 4 -> all outputs zero next edge; a new start then completes with full latency and fresh counts.
REQ-037 cfg1_in/cfg2_in change while busy -> cfg1/cfg2 unchanged until the next accept.
REQ-038 VOTE_CNT=1, SETTLE_CYC=1, race_in=8'h3C -> resp=8'h3C, resp_valid 4 cycles after accept.

Source files
------------

// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: drives a PDL-based arbiter PUF through repeated race
// evaluations of one challenge and majority-votes each response channel.
// Optional feature macro: PUF_STABILITY_EN (per-channel unanimity mask).
module puf_eval_ctrl #(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned CFG_W      = 128,
  parameter int unsigned VOTE_CNT   = 7,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CFG_W-1:0]  cfg1_in,
  input  logic [CFG_W-1:0]  cfg2_in,
  output logic [CFG_W-1:0]  cfg1,
  output logic [CFG_W-1:0]  cfg2,
  output logic              trig,
  input  logic [NUM_CH-1:0] race_in,
  output logic [NUM_CH-1:0] resp,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [NUM_CH-1:0] stable_mask,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(VOTE_CNT + 1);
  localparam int unsigned CYC_W = 8;
  localparam logic [CNT_W-1:0] VOTE_HALF   = CNT_W'(VOTE_CNT / 2);
  localparam logic [CNT_W-1:0] VOTE_FULL   = CNT_W'(VOTE_CNT);
  localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FIRE,
    SAMPLE,
    RECOV,
    DONE
  } state_t;

  state_t            state;
  logic [CYC_W-1:0]  cyc_cnt;
  logic [CNT_W-1:0]  vote_idx;
  logic [CNT_W-1:0]  count [NUM_CH];
  logic [NUM_CH-1:0] resp_c;
  logic              finish_c;

  // Last recovery cycle of the last vote: the next edge enters DONE.
  assign finish_c = (state == RECOV) && (cyc_cnt == SETTLE_LAST) &&
                    (vote_idx >= VOTE_FULL);

  // Majority decision per channel from the accumulated vote counts.
  always_comb begin
    resp_c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      resp_c[i] = (count[i] > VOTE_HALF);
    end
  end

  // Evaluation sequencer with registered trig/resp/handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cfg1       <= '0;
      cfg2       <= '0;
      trig       <= 1'b0;
      resp       <= '0;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
      cyc_cnt    <= '0;
      vote_idx   <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        count[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cfg1     <= cfg1_in;
            cfg2     <= cfg2_in;
            vote_idx <= '0;
            cyc_cnt  <= '0;
            busy     <= 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
              count[i] <= '0;
            end
            state <= LOAD;
          end
        end
        LOAD: begin
          trig    <= 1'b1;
          cyc_cnt <= '0;
          state   <= FIRE;
        end
        FIRE: begin
          if (cyc_cnt == SETTLE_LAST) begin
            state <= SAMPLE;
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        SAMPLE: begin
          for (int i = 0; i < NUM_CH; i++) begin
            count[i] <= count[i] + CNT_W'(race_in[i]);
          end
          vote_idx <= vote_idx + CNT_W'(1);
          trig     <= 1'b0;
          cyc_cnt  <= '0;
          state    <= RECOV;
        end
        RECOV: begin
          if (cyc_cnt == SETTLE_LAST) begin
            if (finish_c) begin
              resp       <= resp_c;
              resp_valid <= 1'b1;
              state      <= DONE;
            end else begin
              trig    <= 1'b1;
              cyc_cnt <= '0;
              state   <= FIRE;
            end
          end else begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
          end
        end
        DONE: begin
          if (resp_valid && resp_ready) begin
            resp_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef PUF_STABILITY_EN
  // Unanimity flag per channel, captured together with resp on DONE entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_mask <= '0;
    end else if (finish_c) begin
      for (int i = 0; i < NUM_CH; i++) begin
        stable_mask[i] <= (count[i] == '0) || (count[i] == VOTE_FULL);
      end
    end
  end
`else
  assign stable_mask = '0;
`endif

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Directed bench for puf_eval_ctrl: default instance plus a VOTE_CNT=1,
// SETTLE_CYC=1 instance. Honours PUF_STABILITY_EN for stable_mask values.
module tb_puf_eval_ctrl;

`ifdef PUF_STABILITY_EN
  localparam bit STAB = 1'b1;
`else
  localparam bit STAB = 1'b0;
`endif

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] cfg1_in, cfg2_in, cfg1, cfg2;
  logic         trig;
  logic [7:0]   race_in, resp, stable_mask;
  logic         resp_valid, resp_ready, busy;

  logic         start1;
  logic [7:0]   cfg1_in1, cfg2_in1, cfg1_1, cfg2_1;
  logic         trig1;
  logic [7:0]   race1, resp1, stable1;
  logic         resp_valid1, resp_ready1, busy1;

  logic [127:0] cfg_a, cfg_b;
  logic [7:0]   vote_pat [7];
  int           n_cmp;
  int           n_bad;
  int           lat, rises;

  puf_eval_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg1_in(cfg1_in), .cfg2_in(cfg2_in), .cfg1(cfg1), .cfg2(cfg2),
    .trig(trig), .race_in(race_in), .resp(resp), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .stable_mask(stable_mask), .busy(busy)
  );

  puf_eval_ctrl #(.NUM_CH(8), .CFG_W(8), .VOTE_CNT(1), .SETTLE_CYC(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1),
    .cfg1_in(cfg1_in1), .cfg2_in(cfg2_in1), .cfg1(cfg1_1), .cfg2(cfg2_1),
    .trig(trig1), .race_in(race1), .resp(resp1), .resp_valid(resp_valid1),
    .resp_ready(resp_ready1), .stable_mask(stable1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept a challenge, feed vote_pat per race, return cycles to resp_valid.
  task automatic run_eval(output int lat_o, output int rises_o);
    logic tp;
    int   n;
    cfg1_in = cfg_a;
    cfg2_in = cfg_b;
    race_in = vote_pat[0];
    start   = 1'b1;
    step();
    start   = 1'b0;
    tp      = trig;
    n       = 0;
    rises_o = 0;
    lat_o   = -1;
    while (n < 300) begin
      step();
      n++;
      if (trig && !tp) begin
        rises_o++;
        if (rises_o <= 7) race_in = vote_pat[rises_o-1];
      end
      tp = trig;
      if (n == 10) begin
        cfg1_in = ~cfg_a;
        cfg2_in = ~cfg_b;
      end
      if (resp_valid) begin
        lat_o = n;
        break;
      end
    end
  endtask

  initial begin
    logic tp;
    int   n;
    n_cmp      = 0;
    n_bad      = 0;
    cfg_a      = {4{32'hDEAD_BEEF}} ^ 128'h1234;
    cfg_b      = {4{32'h0F1E_2D3C}};
    rst        = 1'b1;
    start      = 1'b1;
    cfg1_in    = cfg_a;
    cfg2_in    = cfg_b;
    race_in    = 8'h00;
    resp_ready = 1'b0;
    start1     = 1'b0;
    cfg1_in1   = 8'h5A;
    cfg2_in1   = 8'hC3;
    race1      = 8'h00;
    resp_ready1 = 1'b0;
    for (int k = 0; k < 7; k++) vote_pat[k] = 8'h00;

    // Reset with start held high: nothing may be accepted.
    step();
    step();
    chk("rst_trig", 128'(trig), 128'(0));
    chk("rst_valid", 128'(resp_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_resp", 128'(resp), 128'(0));
    chk("rst_stable", 128'(stable_mask), 128'(0));
    chk("rst_cfg1", cfg1, 128'(0));
    chk("rst_cfg2", cfg2, 128'(0));
    rst   = 1'b0;
    start = 1'b0;
    step();
    chk("idle_busy", 128'(busy), 128'(0));

    // Constant A5 across all votes.
    for (int k = 0; k < 7; k++) vote_pat[k] = 8'hA5;
    run_eval(lat, rises);
    chk("t1_latency", 128'(lat), 128'(64));
    chk("t1_trig_pulses", 128'(rises), 128'(7));
    chk("t1_resp", 128'(resp), 128'(8'hA5));
    chk("t1_stable", 128'(stable_mask), 128'(STAB ? 8'hFF : 8'h00));
    chk("t1_cfg1_held", cfg1, cfg_a);
    chk("t1_cfg2_held", cfg2, cfg_b);
    chk("t1_busy", 128'(busy), 128'(1));

    // Consumer stalls 20 cycles while start pulses arrive.
    for (int i = 0; i < 20; i++) begin
      start = (i % 2 == 0);
      race_in = 8'h00;
      step();
      chk("hold_out", 128'({busy, resp_valid, resp}), 128'({1'b1, 1'b1, 8'hA5}));
    end
    start      = 1'b0;
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    chk("hs_busy", 128'(busy), 128'(0));
    chk("hs_valid", 128'(resp_valid), 128'(0));
    chk("hs_resp_kept", 128'(resp), 128'(8'hA5));

    // Mixed votes: bit0 4 of 7, bit1 3 of 7.
    vote_pat[0] = 8'h03; vote_pat[1] = 8'h03; vote_pat[2] = 8'h03;
    vote_pat[3] = 8'h01; vote_pat[4] = 8'h00; vote_pat[5] = 8'h00;
    vote_pat[6] = 8'h00;
    run_eval(lat, rises);
    chk("t2_latency", 128'(lat), 128'(64));
    chk("t2_resp", 128'(resp), 128'(8'h01));
    chk("t2_stable", 128'(stable_mask), 128'(STAB ? 8'hFC : 8'h00));

    // Start together with handshake in DONE must not accept.
    start      = 1'b1;
    resp_ready = 1'b1;
    step();
    start      = 1'b0;
    resp_ready = 1'b0;
    chk("hs_start_busy", 128'(busy), 128'(0));
    step();
    chk("hs_start_idle", 128'(busy), 128'(0));

    // Reset in the third FIRE cycle of vote 4.
    race_in = 8'hFF;
    cfg1_in = cfg_a;
    cfg2_in = cfg_b;
    start   = 1'b1;
    step();
    start = 1'b0;
    tp    = trig;
    rises = 0;
    n     = 0;
    while (rises < 4 && n < 200) begin
      step();
      n++;
      if (trig && !tp) rises++;
      tp = trig;
    end
    chk("abort_reach_v4", 128'(rises), 128'(4));
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_trig", 128'(trig), 128'(0));
    chk("abort_outs", 128'({busy, resp_valid, resp, stable_mask}), 128'(0));
    chk("abort_cfg", {cfg1[63:0], cfg2[63:0]}, 128'(0));

    // Fresh run after abort: 3 of 7 ones on every bit.
    for (int k = 0; k < 7; k++) vote_pat[k] = (k < 3) ? 8'hFF : 8'h00;
    run_eval(lat, rises);
    chk("t3_latency", 128'(lat), 128'(64));
    chk("t3_resp", 128'(resp), 128'(8'h00));
    chk("t3_stable", 128'(stable_mask), 128'(0));
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;

    // Single-vote, single-settle instance.
    race1  = 8'h3C;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 50; i++) begin
      step();
      if (resp_valid1) begin
        lat = i;
        break;
      end
    end
    chk("v1_latency", 128'(lat), 128'(4));
    chk("v1_resp", 128'(resp1), 128'(8'h3C));
    chk("v1_stable", 128'(stable1), 128'(STAB ? 8'hFF : 8'h00));
    chk("v1_cfg", 128'({cfg1_1, cfg2_1}), 128'(16'h5AC3));
    resp_ready1 = 1'b1;
    step();
    resp_ready1 = 1'b0;
    chk("v1_hs_busy", 128'(busy1), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
